// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and FSM encoding for the ALU arbiter.
package alu_pkg;
    localparam int DW   = 19;
    localparam int FW   = 8;
    localparam int OPW  = 6;
    localparam int IMMW = 3;

    localparam logic [OPW-1:0] OP_ADD = 6'd1;
    localparam logic [OPW-1:0] OP_SUB = 6'd2;
    localparam logic [OPW-1:0] OP_MUL = 6'd3;
    localparam logic [OPW-1:0] OP_DIV = 6'd4;
    localparam logic [OPW-1:0] OP_AND = 6'd7;
    localparam logic [OPW-1:0] OP_OR  = 6'd8;
    localparam logic [OPW-1:0] OP_XOR = 6'd9;
    localparam logic [OPW-1:0] OP_NOT = 6'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request at/after ptr+1, wrapping.
// Combinational, zero latency; no backpressure (pure function of inputs).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    always_comb begin : pick
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = PW'(j);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU among NREQ requesters; ARB_LOCK_EN adds req_lock (sticky grant).
// Latency: accept T, ALU enabled T+1..T+LAT, result captured T+LAT+1, rsp_valid at T+LAT+2.
// Backpressure: accepts only in IDLE via one-hot req_ready; responses cannot be stalled.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OPW-1:0]  req_opcode,
    input  logic [NREQ*DW-1:0]   req_r2,
    input  logic [NREQ*DW-1:0]   req_r3,
    input  logic [NREQ*IMMW-1:0] req_imm,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_r1,
    output logic [FW-1:0]        rsp_flag,
    output logic                 alu_en,
    output logic [OPW-1:0]       alu_opcode,
    output logic [DW-1:0]        alu_r2,
    output logic [DW-1:0]        alu_r3,
    output logic [IMMW-1:0]      alu_imm,
    input  logic [DW-1:0]        alu_r1,
    input  logic [FW-1:0]        alu_flag,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, win_q, sel_idx, arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic            arb_any, sel_any, accept;
    logic [OPW-1:0]  op_q, sel_op;
    logic [DW-1:0]   r2_q, r3_q;
    logic [IMMW-1:0] imm_q;
    logic [7:0]      cnt;

    function automatic logic [7:0] lat_of(input logic [OPW-1:0] op);
        case (op)
            OP_MUL:  lat_of = 8'(MUL_LAT);
            OP_DIV:  lat_of = 8'(DIV_LAT);
            default: lat_of = 8'd1;
        endcase
    endfunction

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef ARB_LOCK_EN
    logic lock_hold, lock_win;
    // A locked winner that is still requesting bypasses rotation for one IDLE cycle.
    assign lock_win = lock_hold && req_valid[win_q];
    assign sel_idx  = lock_win ? win_q : arb_idx;
    assign sel_any  = lock_win || arb_any;
`else
    assign sel_idx  = arb_idx;
    assign sel_any  = arb_any;
`endif

    assign accept     = reset && (state == ST_IDLE) && sel_any;
    assign sel_op     = req_opcode[sel_idx*OPW +: OPW];
    assign req_ready  = accept ? (ONE << sel_idx) : '0;
    assign rsp_valid  = (state == ST_RESP) ? (ONE << win_q) : '0;
    assign busy       = (state != ST_IDLE);
    assign alu_en     = (state == ST_EXEC);
    assign alu_opcode = alu_en ? op_q  : '0;
    assign alu_r2     = alu_en ? r2_q  : '0;
    assign alu_r3     = alu_en ? r3_q  : '0;
    assign alu_imm    = alu_en ? imm_q : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == 8'd0) state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= PW'(NREQ - 1);
            win_q    <= '0;
            op_q     <= '0;
            r2_q     <= '0;
            r3_q     <= '0;
            imm_q    <= '0;
            cnt      <= '0;
            rsp_r1   <= '0;
            rsp_flag <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                win_q <= sel_idx;
                op_q  <= sel_op;
                r2_q  <= req_r2[sel_idx*DW +: DW];
                r3_q  <= req_r3[sel_idx*DW +: DW];
                imm_q <= req_imm[sel_idx*IMMW +: IMMW];
                cnt   <= lat_of(sel_op) - 8'd1;
            end else if (state == ST_EXEC && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (state == ST_CAP) begin
                rsp_r1   <= alu_r1;
                rsp_flag <= alu_flag;
            end
`ifdef ARB_LOCK_EN
            if (state == ST_RESP && !req_lock[win_q]) ptr <= win_q;
`else
            if (state == ST_RESP) ptr <= win_q;
`endif
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 lock_hold <= 1'b0;
        else if (state == ST_RESP)  lock_hold <= req_lock[win_q];
        else if (state == ST_IDLE)  lock_hold <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model standing in for the real ALU.
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OPW-1:0]  req_opcode;
    logic [NREQ*DW-1:0]   req_r2, req_r3;
    logic [NREQ*IMMW-1:0] req_imm;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]      req_lock;
`endif
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]        rsp_r1, alu_r2, alu_r3;
    logic [FW-1:0]        rsp_flag;
    logic                 alu_en, busy;
    logic [OPW-1:0]       alu_opcode;
    logic [IMMW-1:0]      alu_imm;
    logic [DW-1:0]        alu_r1   = '0;
    logic [FW-1:0]        alu_flag = '0;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NREQ(NREQ), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_r2     (req_r2),
        .req_r3     (req_r3),
        .req_imm    (req_imm),
`ifdef ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_r1     (rsp_r1),
        .rsp_flag   (rsp_flag),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .alu_r2     (alu_r2),
        .alu_r3     (alu_r3),
        .alu_imm    (alu_imm),
        .alu_r1     (alu_r1),
        .alu_flag   (alu_flag),
        .busy       (busy)
    );

    // Registered ALU: known ops flag their own opcode, unknown ops return a fixed default.
    always @(posedge clk) begin
        if (alu_en) begin
            alu_flag <= {2'b00, alu_opcode};
            case (alu_opcode)
                OP_ADD: alu_r1 <= alu_r2 + alu_r3;
                OP_SUB: alu_r1 <= alu_r2 - alu_r3;
                OP_MUL: alu_r1 <= alu_r2 * alu_r3;
                OP_DIV: begin
                    if (alu_r3 == '0) begin
                        alu_r1   <= '0;
                        alu_flag <= 8'hDD;
                    end else begin
                        alu_r1 <= alu_r2 / alu_r3;
                    end
                end
                OP_AND: alu_r1 <= alu_r2 & alu_r3;
                OP_OR:  alu_r1 <= alu_r2 | alu_r3;
                OP_XOR: alu_r1 <= alu_r2 ^ alu_r3;
                OP_NOT: alu_r1 <= ~alu_r2;
                default: begin
                    alu_r1   <= 19'h07ABC;
                    alu_flag <= 8'hA5;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [5:0] op, input logic [18:0] a,
                           input logic [18:0] b, input logic [2:0] imm);
        req_opcode[i*OPW +: OPW] = op;
        req_r2[i*DW +: DW]       = a;
        req_r3[i*DW +: DW]       = b;
        req_imm[i*IMMW +: IMMW]  = imm;
        req_valid[i]             = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check("idle_wait", busy, 0);
    endtask

    // Issues one request from an idle DUT and checks the whole op timeline.
    task automatic run_op(input int i, input logic [5:0] op, input logic [18:0] a,
                          input logic [18:0] b, input logic [2:0] imm, input int lat,
                          input logic [18:0] er1, input logic [7:0] ef);
        int en_cnt, first_en, rsp_k, busy_cnt;
        en_cnt = 0; first_en = -1; rsp_k = -1; busy_cnt = 0;
        @(negedge clk);
        set_req(i, op, a, b, imm);
        #1;
        check("ready", req_ready, 1 << i);
        check("busy_idle", busy, 0);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = '0;
            #1;
            if (req_ready != '0) check("ready_busy", req_ready, 0);
            if (alu_en) begin
                en_cnt++;
                if (first_en < 0) begin
                    first_en = k;
                    check("alu_op", alu_opcode, op);
                    check("alu_r2", alu_r2, a);
                    check("alu_r3", alu_r3, b);
                    check("alu_imm", alu_imm, imm);
                end
            end else if (alu_opcode != '0) begin
                check("alu_op_off", alu_opcode, 0);
            end
            if (busy) busy_cnt++;
            if (rsp_valid != '0) begin
                rsp_k = k;
                check("rsp_vld", rsp_valid, 1 << i);
                check("rsp_r1", rsp_r1, er1);
                check("rsp_flag", rsp_flag, ef);
            end
        end
        check("en_cnt", en_cnt, lat);
        check("first_en", first_en, 1);
        check("rsp_cyc", rsp_k, lat + 2);
        check("busy_cnt", busy_cnt, lat + 2);
        check("busy_end", busy, 0);
        check("r1_hold", rsp_r1, er1);
    endtask

    initial begin
        int g, r, last;
        logic drop;
        reset      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_r2     = '0;
        req_r3     = '0;
        req_imm    = '0;
`ifdef ARB_LOCK_EN
        req_lock   = '0;
`endif
        @(negedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_en", alu_en, 0);
        check("rst_r1", rsp_r1, 0);
        check("rst_flag", rsp_flag, 0);
        @(negedge clk);
        reset = 1'b1;

        // single ADD, LAT 1
        run_op(0, OP_ADD, 19'd10, 19'd15, 3'd0, 1, 19'd25, 8'h01);

        // four requesters contending: grants 0,1,2,3,0 at 4-cycle spacing
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_req(i, OP_SUB, 19'd20, 19'd5, 3'(i));
        g = 0; r = 0; last = 0; drop = 1'b0;
        for (int c = 0; c < 60 && r < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (drop) begin
                req_valid = '0;
                drop      = 1'b0;
            end
            #1;
            if (req_ready != '0) begin
                check("rr_grant", req_ready, 1 << (g % 4));
                if (g > 0) check("rr_gap", c - last, 4);
                last = c;
                g++;
                if (g == 5) drop = 1'b1;
            end
            if (rsp_valid != '0) begin
                check("rr_rsp", rsp_valid, 1 << (r % 4));
                check("rr_r1", rsp_r1, 15);
                r++;
            end
        end
        check("rr_rsp_count", r, 5);
        wait_idle();

        // multi-cycle ops and other patterns
        run_op(1, OP_DIV, 19'd40, 19'd8, 3'd2, 4, 19'd5, 8'h04);
        run_op(2, OP_MUL, 19'd3, 19'd4, 3'd1, 2, 19'd12, 8'h03);
        run_op(0, OP_XOR, 19'h05A5A, 19'h00FF0, 3'd7, 1, 19'h055AA, 8'h09);
        run_op(1, OP_NOT, 19'h00000, 19'h12345, 3'd0, 1, 19'h7FFFF, 8'h0B);
        run_op(3, OP_DIV, 19'd9, 19'd0, 3'd0, 4, 19'd0, 8'hDD);
        run_op(3, 6'h3F, 19'd7, 19'd9, 3'd5, 1, 19'h07ABC, 8'hA5);

        // reset in the middle of a DIV
        @(negedge clk);
        set_req(2, OP_DIV, 19'd40, 19'd8, 3'd0);
        #1;
        check("mid_ready", req_ready, 4);
        @(negedge clk);
        #1;
        check("mid_en", alu_en, 1);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 19'd1, 19'd2, 3'd0);
        #1;
        check("mid_rst_en", alu_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_op", alu_opcode, 0);
        check("mid_rst_r2", alu_r2, 0);
        check("mid_rst_r1", rsp_r1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("mid_rst_rsp", rsp_valid, 0);
            check("mid_rst_ready", req_ready, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 1);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        check("post_rst_r1", rsp_r1, 3);

`ifdef ARB_LOCK_EN
        // locked requester keeps winning until the lock drops
        reset_dut();
        set_req(0, OP_ADD, 19'd1, 19'd1, 3'd0);
        set_req(1, OP_ADD, 19'd2, 19'd2, 3'd0);
        req_lock = 4'b0001;
        g = 0;
        for (int c = 0; c < 60 && g < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                check("lock_grant", req_ready, (g < 3) ? 1 : 2);
                g++;
                if (g == 3) req_lock = '0;
            end
        end
        check("lock_count", g, 4);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
